// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Shares the single-port synchronous DMEM between the core and a debug/loader
//  port. Optional starvation guard when ARB_STARVE_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ISSUE_CPU = 3'd1;
    localparam logic [2:0] c_ISSUE_DBG = 3'd2;
    localparam logic [2:0] c_RESP_CPU  = 3'd3;
    localparam logic [2:0] c_RESP_DBG  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              w_grant_cpu;
    logic              w_grant_dbg;
    logic              w_dbg_priority;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_wren;
    logic              r_mem_rden;
    logic [DATA_W-1:0] r_cpu_hold;
    logic [DATA_W-1:0] r_dbg_hold;

`ifdef ARB_STARVE_EN
    localparam int c_CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_WAIT);

    logic [c_CNT_W-1:0] r_wait_cnt;

    assign w_dbg_priority = (r_wait_cnt == c_MAX_CNT);

    // Counts consecutive IDLE decisions where debug lost to the core.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_IDLE) begin
            if (!dbg_req || w_grant_dbg) begin
                r_wait_cnt <= '0;
            end else if (w_grant_cpu && (r_wait_cnt != c_MAX_CNT)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_dbg_priority = 1'b0;
    assign w_unused_cfg   = (MAX_WAIT != 0);
`endif

    assign w_grant_cpu = cpu_req & ~(dbg_req & w_dbg_priority);
    assign w_grant_dbg = dbg_req & ~w_grant_cpu;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cpu_ack     = 1'b0;
        dbg_ack     = 1'b0;
        cpu_rdata   = r_cpu_hold;
        dbg_rdata   = r_dbg_hold;
        case (r_state)
            c_IDLE: begin
                if (w_grant_cpu) begin
                    w_state_nxt = c_ISSUE_CPU;
                end else if (w_grant_dbg) begin
                    w_state_nxt = c_ISSUE_DBG;
                end
            end
            c_ISSUE_CPU: w_state_nxt = c_RESP_CPU;
            c_ISSUE_DBG: w_state_nxt = c_RESP_DBG;
            c_RESP_CPU: begin
                w_state_nxt = c_IDLE;
                cpu_ack     = 1'b1;
                if (!r_we) begin
                    cpu_rdata = mem_rdata;
                end
            end
            c_RESP_DBG: begin
                w_state_nxt = c_IDLE;
                dbg_ack     = 1'b1;
                if (!r_we) begin
                    dbg_rdata = mem_rdata;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Strobes are loaded on the IDLE->ISSUE edge, so they are high only in ISSUE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
            r_mem_rden  <= 1'b0;
            r_cpu_hold  <= '0;
            r_dbg_hold  <= '0;
        end else begin
            r_mem_wren <= 1'b0;
            r_mem_rden <= 1'b0;
            if (r_state == c_IDLE && w_grant_cpu) begin
                r_we        <= cpu_we;
                r_mem_addr  <= cpu_addr;
                r_mem_wdata <= cpu_wdata;
                r_mem_wren  <= cpu_we;
                r_mem_rden  <= ~cpu_we;
            end else if (r_state == c_IDLE && w_grant_dbg) begin
                r_we        <= dbg_we;
                r_mem_addr  <= dbg_addr;
                r_mem_wdata <= dbg_wdata;
                r_mem_wren  <= dbg_we;
                r_mem_rden  <= ~dbg_we;
            end
            if (r_state == c_RESP_CPU && !r_we) begin
                r_cpu_hold <= mem_rdata;
            end
            if (r_state == c_RESP_DBG && !r_we) begin
                r_dbg_hold <= mem_rdata;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_ack;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wren  = r_mem_wren;
    assign mem_rden  = r_mem_rden;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Scoreboard bench for dmem_arbiter with a synchronous RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        CLK;
    logic        RESET;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_wren, mem_rden;

    logic [31:0] ram [0:1023];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wren_cnt = 0;
    logic [31:0] cpu_q [$];
    logic [31:0] dbg_q [$];
    logic        grant_log [$];

    dmem_arbiter #(.DATA_W(32), .ADDR_W(10), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rden(mem_rden), .mem_rdata(mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_wren) ram[mem_addr] <= mem_wdata;
        if (mem_rden) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected read data whenever a port is acknowledged.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (mem_wren) wren_cnt++;
            if (cpu_ack) begin
                grant_log.push_back(1'b0);
                if (cpu_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL cpu_ack_unexpected: ack=1 with no pending request");
                end else begin
                    check("cpu_rdata_at_ack", cpu_rdata, cpu_q.pop_front());
                end
            end
            if (dbg_ack) begin
                grant_log.push_back(1'b1);
                if (dbg_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL dbg_ack_unexpected: ack=1 with no pending request");
                end else begin
                    check("dbg_rdata_at_ack", dbg_rdata, dbg_q.pop_front());
                end
            end
        end
    end

    task automatic cpu_access(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp, output int lat);
        logic got = 1'b0;
        lat = 0;
        cpu_q.push_back(exp);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge CLK); #1;
            if (cpu_ack) begin got = 1'b1; lat = i; end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL cpu_ack_timeout: no ack within 20 cycles, required ack");
        end
        cpu_req = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic dbg_access(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp, output int lat);
        logic got = 1'b0;
        lat = 0;
        dbg_q.push_back(exp);
        dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge CLK); #1;
            if (dbg_ack) begin got = 1'b1; lat = i; end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL dbg_ack_timeout: no ack within 20 cycles, required ack");
        end
        dbg_req = 1'b0;
        @(posedge CLK); #1;
    endtask

    function automatic logic exp_dbg_grant(input int k);
`ifdef ARB_STARVE_EN
        return (k % 5) == 4;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_c;
        int lat_d;
        int w0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        pre_we = 0; pre_addr = 0; pre_data = 0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        pre_we = 1; pre_addr = 10'h010; pre_data = 32'hDEADBEEF;
        @(posedge CLK); #1;
        pre_addr = 10'h020; pre_data = 32'h0;
        @(posedge CLK); #1;
        pre_addr = 10'h030; pre_data = 32'h00000055;
        @(posedge CLK); #1;
        pre_we = 0;

        check("rst_mem_wren", {31'b0, mem_wren}, 0);
        check("rst_mem_rden", {31'b0, mem_rden}, 0);
        check("rst_cpu_ack", {31'b0, cpu_ack}, 0);
        check("rst_dbg_ack", {31'b0, dbg_ack}, 0);
        check("rst_mem_addr", {22'b0, mem_addr}, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Core read with cycle-level strobe checks
        fork
            cpu_access(1'b0, 10'h010, 32'h0, 32'hDEADBEEF, lat_c);
            begin
                @(negedge CLK);
                check("t1_stall_n", {31'b0, cpu_stall}, 1);
                check("t1_rden_n", {31'b0, mem_rden}, 0);
                @(negedge CLK);
                check("t1_rden_n1", {31'b0, mem_rden}, 1);
                check("t1_wren_n1", {31'b0, mem_wren}, 0);
                check("t1_addr_n1", {22'b0, mem_addr}, 32'h010);
                check("t1_stall_n1", {31'b0, cpu_stall}, 1);
                check("t1_ack_n1", {31'b0, cpu_ack}, 0);
                @(negedge CLK);
                check("t1_rden_n2", {31'b0, mem_rden}, 0);
                check("t1_ack_n2", {31'b0, cpu_ack}, 1);
                check("t1_stall_n2", {31'b0, cpu_stall}, 0);
            end
        join
        check("t1_latency", lat_c, 2);

        // Debug write then core read of the same word
        w0 = wren_cnt;
        dbg_access(1'b1, 10'h005, 32'h12345678, 32'h0, lat_d);
        check("t2_wren_cycles", wren_cnt - w0, 1);
        cpu_access(1'b0, 10'h005, 32'h0, 32'h12345678, lat_c);

        // Give the debug port a non-zero hold value
        dbg_access(1'b0, 10'h005, 32'h0, 32'h12345678, lat_d);

        // Simultaneous single-shot requests
        fork
            cpu_access(1'b0, 10'h010, 32'h0, 32'hDEADBEEF, lat_c);
            dbg_access(1'b0, 10'h005, 32'h0, 32'h12345678, lat_d);
            begin
                @(posedge CLK); @(posedge CLK); #2;
                check("t3_cpu_ack_in_resp", {31'b0, cpu_ack}, 1);
                check("t3_dbg_hold_in_cpu_resp", dbg_rdata, 32'h12345678);
                check("t3_dbg_ack_in_cpu_resp", {31'b0, dbg_ack}, 0);
            end
        join
        check("t3_cpu_latency", lat_c, 2);
        check("t3_dbg_latency", lat_d, 5);

        // Continuous contention
        grant_log.delete();
        for (int k = 0; k < 10; k++) begin
            if (exp_dbg_grant(k)) dbg_q.push_back(32'h12345678);
            else cpu_q.push_back(32'hDEADBEEF);
        end
        cpu_we = 0; cpu_addr = 10'h010; cpu_req = 1;
        dbg_we = 0; dbg_addr = 10'h005; dbg_req = 1;
        repeat (30) @(posedge CLK);
        #1;
        cpu_req = 0; dbg_req = 0;
        @(posedge CLK); #1;
        check("t4_grant_count", grant_log.size(), 10);
        for (int k = 0; k < 10; k++) begin
            logic [31:0] g;
            g = (k < grant_log.size()) ? {31'b0, grant_log[k]} : 32'd2;
            check($sformatf("t4_grant%0d_is_dbg", k), g, {31'b0, exp_dbg_grant(k)});
        end

        // Reset during the ISSUE cycle of a core write
        cpu_we = 1; cpu_addr = 10'h020; cpu_wdata = 32'hAAAA5555; cpu_req = 1;
        @(posedge CLK); #1;
        check("t5_wren_in_issue", {31'b0, mem_wren}, 1);
        RESET = 1'b1;
        #1;
        check("t5_wren_async_drop", {31'b0, mem_wren}, 0);
        check("t5_ack_in_reset", {31'b0, cpu_ack}, 0);
        cpu_req = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("t5_cpu_rdata_after_rst", cpu_rdata, 0);
        @(posedge CLK); #1;
        cpu_access(1'b0, 10'h020, 32'h0, 32'h0, lat_c);
        check("t5_idle_latency", lat_c, 2);

        // Idle hold
        cpu_access(1'b0, 10'h010, 32'h0, 32'hDEADBEEF, lat_c);
        dbg_access(1'b0, 10'h005, 32'h0, 32'h12345678, lat_d);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check($sformatf("t6_strobes_c%0d", i),
                  {28'b0, mem_wren, mem_rden, cpu_ack, dbg_ack}, 0);
            check($sformatf("t6_cpu_hold_c%0d", i), cpu_rdata, 32'hDEADBEEF);
            check($sformatf("t6_dbg_hold_c%0d", i), dbg_rdata, 32'h12345678);
        end
        @(posedge CLK); #1;

        // Core write keeps the previous hold value, then read back
        cpu_access(1'b1, 10'h030, 32'h0BADF00D, 32'hDEADBEEF, lat_c);
        cpu_access(1'b0, 10'h030, 32'h0, 32'h0BADF00D, lat_c);

        check("cpu_q_drained", cpu_q.size(), 0);
        check("dbg_q_drained", dbg_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
